gb_clock_ctrl: RTL and testbench
================================

// Module: gb_clock_ctrl
// PURPOSE
//   Clock-enable scheduler for the Game Boy core. Divides one master clock into
//   single-cycle enables: ce_cpu (CPU/timer domain) and ce_ppu (video domain).
//   Sequences the CGB speed switch (normal <-> double) with a fixed pause.
//   Lets the debugger halt all enables at a clean CPU boundary.
// PARAMETERS
//   DIV_NORMAL     4     clk_in cycles per ce_cpu at normal speed; also the ce_ppu period
//   DIV_DOUBLE     2     clk_in cycles per ce_cpu at double speed
//   SWITCH_CYCLES  8200  clk_in cycles that ce_cpu stays silent during a speed switch
//   CNT_W          16    counter width; must hold SWITCH_CYCLES-1 and DIV_NORMAL-1
// PORTS
//   clk_in        in   1  master clock
//   reset_n       in   1  asynchronous reset, active low
//   switch_req    in   1  CPU STOP with KEY1 armed; level, re-armed only after it returns low
//   halt_req      in   1  debugger halt request, level
//   step          in   1  debugger single-step pulse (used only with CLOCK_CTRL_STEP_EN)
//   ce_cpu        out  1  CPU clock enable, one clk_in cycle wide
//   ce_ppu        out  1  PPU clock enable, one clk_in cycle wide
//   double_speed  out  1  1 = double-speed mode active
//   switch_done   out  1  one-cycle pulse when the speed switch completes
//   halt_ack      out  1  high while the controller is in HALT
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset values: ce_cpu=0, ce_ppu=0, double_speed=0, switch_done=0, halt_ack=0, state=RUN.
//   - Reset loads cpu_cnt and ppu_cnt with DIV_NORMAL-1 and sets the rearm flag to 1.
//   - div = double_speed ? DIV_DOUBLE : DIV_NORMAL.
//   - cpu_cnt counts down. At 0 it reloads div-1 (the boundary).
//   - In RUN, ce_cpu=1 in the cycle after a boundary, so the period is exactly div.
//   - First ce_cpu after reset is asserted at clk_in edge DIV_NORMAL.
//   - ppu_cnt counts down from DIV_NORMAL-1 and is independent of double_speed.
//   - ce_ppu=1 after each wrap of ppu_cnt.
//   - ppu_cnt runs in RUN and SWITCH and is frozen in HALT.
//   - FSM states: RUN, SWITCH, HALT.
//   - RUN -> SWITCH: at a boundary with switch_req=1 and rearm=1.
//       - No ce_cpu is issued for that boundary.
//       - wait_cnt loads SWITCH_CYCLES-1 and rearm clears to 0.
//   - RUN -> HALT: at a boundary with halt_req=1 and no switch taken.
//       - No ce_cpu is issued for that boundary.
//       - halt_ack=1 from the next cycle.
//   - If switch and halt are both pending at a boundary, SWITCH wins.
//       - The halt is then taken at the first boundary after returning to RUN.
//   - SWITCH: wait_cnt decrements every cycle and halt_req is ignored.
//       - At wait_cnt==0: double_speed toggles and switch_done pulses for 1 cycle.
//       - cpu_cnt reloads the new div-1 and the FSM goes to RUN.
//       - First new-speed ce_cpu is asserted new-div cycles after switch_done.
//   - HALT -> RUN: when halt_req=0. halt_ack drops in the same cycle the FSM leaves HALT.
//       - cpu_cnt reloads div-1, so the first ce_cpu comes div cycles later.
//   - Rearm: rearm sets to 1 on any cycle with switch_req=0.
//       - A switch_req held high after switch_done does not start a second switch.
//   - Reset asserted mid-switch: reset values apply (normal speed, no switch_done pulse).
//   - switch_req is ignored while in HALT. It is evaluated at the first boundary back in RUN.
// CONFIGURATION
//   - CLOCK_CTRL_STEP_EN defined:
//       - In HALT, step=1 makes ce_cpu=1 for exactly one cycle, on the next cycle.
//       - The FSM stays in HALT, halt_ack stays 1 and ce_ppu stays frozen.
//       - step pulses on consecutive cycles each yield one ce_cpu.
//       - step outside HALT is ignored.
//   - CLOCK_CTRL_STEP_EN undefined:
//       - The step port exists but is ignored, and no step logic is synthesized.
// TESTING
//   1. Reset release, idle inputs:
//        ce_cpu and ce_ppu each pulse every 4 cycles, in phase; 100 cycles give 25 of each.
//   2. Single speed switch (switch_req=1, SWITCH_CYCLES=8200):
//        ce_cpu silent for 8200 cycles, then switch_done pulses once and double_speed=1.
//        ce_cpu then runs at period 2 while ce_ppu keeps period 4 throughout.
//   3. switch_req held high through switch_done:
//        no second switch occurs.
//        Drop switch_req for 1 cycle and raise it again: the switch back to period 4 happens.
//   4. halt_req raised mid-period:
//        halt_ack=1 right after the next boundary and no ce_cpu/ce_ppu while halted.
//        Release halt_req: first ce_cpu appears 4 cycles later.
//   5. halt_req and switch_req both high at the same boundary:
//        the switch completes first, then the halt is taken at the next boundary.
//        Assert reset_n=0 at wait_cnt=100: double_speed=0 and no switch_done pulse.
//   6. CLOCK_CTRL_STEP_EN build, in HALT, three step pulses:
//        exactly 3 ce_cpu, 0 ce_ppu, halt_ack stays 1.
//      Non-step build, same stimulus: 0 ce_cpu.

Source files
------------

// File: rtl/gb_clock_ctrl_if.sv
// Control/enable bundle between the Game Boy core and its clock-enable scheduler.
// master = core/debugger side (drives requests), slave = the scheduler.
interface gb_clock_ctrl_if;
    logic switch_req;
    logic halt_req;
    logic step;
    logic ce_cpu;
    logic ce_ppu;
    logic double_speed;
    logic switch_done;
    logic halt_ack;

    modport master (
        output switch_req,
        output halt_req,
        output step,
        input  ce_cpu,
        input  ce_ppu,
        input  double_speed,
        input  switch_done,
        input  halt_ack
    );

    modport slave (
        input  switch_req,
        input  halt_req,
        input  step,
        output ce_cpu,
        output ce_ppu,
        output double_speed,
        output switch_done,
        output halt_ack
    );
endinterface

// File: rtl/gb_clock_ctrl.sv
// Game Boy clock-enable scheduler: CPU/PPU enables, CGB speed switch, debugger halt.
// Optional debugger single-step inside HALT is built only when CLOCK_CTRL_STEP_EN is defined.
module gb_clock_ctrl #(
    parameter int unsigned DIV_NORMAL    = 4,
    parameter int unsigned DIV_DOUBLE    = 2,
    parameter int unsigned SWITCH_CYCLES = 8200,
    parameter int unsigned CNT_W         = 16
) (
    input  logic           clk_in,
    input  logic           reset_n,
    gb_clock_ctrl_if.slave ctrl
);

    localparam logic [CNT_W-1:0] RELOAD_NORMAL = CNT_W'(DIV_NORMAL - 1);
    localparam logic [CNT_W-1:0] RELOAD_DOUBLE = CNT_W'(DIV_DOUBLE - 1);
    localparam logic [CNT_W-1:0] RELOAD_WAIT   = CNT_W'(SWITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cpu_cnt_q;
    logic [CNT_W-1:0] ppu_cnt_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             rearm_q;
    logic             ce_cpu_q;
    logic             ce_ppu_q;
    logic             double_speed_q;
    logic             switch_done_q;
    logic             halt_ack_q;

    logic [CNT_W-1:0] ppu_cnt_d;
    logic             ce_ppu_d;
    logic             rearm_d;
    logic [CNT_W-1:0] reload_cur;
    logic [CNT_W-1:0] reload_swapped;
    logic             cpu_boundary;
    logic             switch_take;

    // The video divider ignores speed mode and only stops while halted.
    always_comb begin
        ppu_cnt_d = ppu_cnt_q;
        ce_ppu_d  = 1'b0;
        if (state_q != ST_HALT) begin
            ce_ppu_d  = (ppu_cnt_q == '0);
            ppu_cnt_d = (ppu_cnt_q == '0) ? RELOAD_NORMAL : ppu_cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        reload_cur     = double_speed_q ? RELOAD_DOUBLE : RELOAD_NORMAL;
        reload_swapped = double_speed_q ? RELOAD_NORMAL : RELOAD_DOUBLE;
        cpu_boundary   = (cpu_cnt_q == '0);
        switch_take    = (state_q == ST_RUN) && cpu_boundary && ctrl.switch_req && rearm_q;
        // switch_req must drop once before another switch may start
        rearm_d        = rearm_q;
        if (switch_take) begin
            rearm_d = 1'b0;
        end else if (!ctrl.switch_req) begin
            rearm_d = 1'b1;
        end
    end

`ifndef CLOCK_CTRL_STEP_EN
    logic unused_step;
    assign unused_step = ctrl.step;
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_RUN;
            cpu_cnt_q      <= RELOAD_NORMAL;
            ppu_cnt_q      <= RELOAD_NORMAL;
            wait_cnt_q     <= '0;
            rearm_q        <= 1'b1;
            ce_cpu_q       <= 1'b0;
            ce_ppu_q       <= 1'b0;
            double_speed_q <= 1'b0;
            switch_done_q  <= 1'b0;
            halt_ack_q     <= 1'b0;
        end else begin
            ce_cpu_q      <= 1'b0;
            switch_done_q <= 1'b0;
            ce_ppu_q      <= ce_ppu_d;
            ppu_cnt_q     <= ppu_cnt_d;
            rearm_q       <= rearm_d;

            case (state_q)
                ST_RUN: begin
                    if (cpu_boundary) begin
                        cpu_cnt_q <= reload_cur;
                        // A boundary consumed by a switch or halt issues no enable.
                        if (switch_take) begin
                            state_q    <= ST_SWITCH;
                            wait_cnt_q <= RELOAD_WAIT;
                        end else if (ctrl.halt_req) begin
                            state_q    <= ST_HALT;
                            halt_ack_q <= 1'b1;
                        end else begin
                            ce_cpu_q <= 1'b1;
                        end
                    end else begin
                        cpu_cnt_q <= cpu_cnt_q - CNT_ONE;
                    end
                end

                ST_SWITCH: begin
                    if (wait_cnt_q == '0) begin
                        double_speed_q <= ~double_speed_q;
                        switch_done_q  <= 1'b1;
                        cpu_cnt_q      <= reload_swapped;
                        state_q        <= ST_RUN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_ONE;
                    end
                end

                ST_HALT: begin
                    if (!ctrl.halt_req) begin
                        state_q    <= ST_RUN;
                        halt_ack_q <= 1'b0;
                        cpu_cnt_q  <= reload_cur;
                    end
`ifdef CLOCK_CTRL_STEP_EN
                    else if (ctrl.step) begin
                        ce_cpu_q <= 1'b1;
                    end
`endif
                end

                default: begin
                    state_q    <= ST_RUN;
                    halt_ack_q <= 1'b0;
                    cpu_cnt_q  <= reload_cur;
                end
            endcase
        end
    end

    assign ctrl.ce_cpu       = ce_cpu_q;
    assign ctrl.ce_ppu       = ce_ppu_q;
    assign ctrl.double_speed = double_speed_q;
    assign ctrl.switch_done  = switch_done_q;
    assign ctrl.halt_ack     = halt_ack_q;

endmodule

// File: tb/tb_gb_clock_ctrl.sv
// Bench for gb_clock_ctrl: directed scenario sequence with randomized timing,
// every cycle compared against an age-counting reference of the scheduling rules.
module tb_gb_clock_ctrl;

    localparam int DIV_N  = 4;
    localparam int DIV_D  = 2;
    localparam int SW_CYC = 8200;
`ifdef CLOCK_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    localparam int MODE_RUN    = 0;
    localparam int MODE_SWITCH = 1;
    localparam int MODE_HALT   = 2;

    logic clk_in;
    logic reset_n;

    gb_clock_ctrl_if ctrl ();

    gb_clock_ctrl #(
        .DIV_NORMAL   (DIV_N),
        .DIV_DOUBLE   (DIV_D),
        .SWITCH_CYCLES(SW_CYC),
        .CNT_W        (16)
    ) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .ctrl   (ctrl)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // reference state
    int m_mode, m_cpu_age, m_ppu_age, m_sw_elapsed;
    bit m_ds, m_armed;
    bit exp_ce_cpu, exp_ce_ppu, exp_done, exp_ack;

    // observation bookkeeping
    int cyc = 0;
    int n_cpu = 0, n_ppu = 0, n_done = 0;
    int last_cpu_cyc = 0, last_ppu_cyc = 0, done_cyc = 0;
    bit chk_ppu_gap = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        m_mode = MODE_RUN; m_cpu_age = 0; m_ppu_age = 0; m_sw_elapsed = 0;
        m_ds = 1'b0; m_armed = 1'b1;
        exp_ce_cpu = 1'b0; exp_ce_ppu = 1'b0; exp_done = 1'b0; exp_ack = 1'b0;
    endtask

    // One clk_in edge of the scheduling rules, using inputs as they stood before the edge.
    task automatic model_edge();
        bit sw, hr, st;
        int div;
        sw = ctrl.switch_req; hr = ctrl.halt_req; st = ctrl.step;
        exp_ce_cpu = 1'b0; exp_ce_ppu = 1'b0; exp_done = 1'b0;
        div = m_ds ? DIV_D : DIV_N;
        if (m_mode != MODE_HALT) begin
            exp_ce_ppu = (m_ppu_age == DIV_N - 1);
            m_ppu_age  = (m_ppu_age + 1) % DIV_N;
        end
        case (m_mode)
            MODE_RUN: begin
                if (m_cpu_age == div - 1) begin
                    m_cpu_age = 0;
                    if (sw && m_armed) begin
                        m_mode = MODE_SWITCH; m_sw_elapsed = 0; m_armed = 1'b0;
                    end else if (hr) begin
                        m_mode = MODE_HALT; exp_ack = 1'b1;
                    end else begin
                        exp_ce_cpu = 1'b1;
                    end
                end else begin
                    m_cpu_age++;
                end
            end
            MODE_SWITCH: begin
                m_sw_elapsed++;
                if (m_sw_elapsed == SW_CYC) begin
                    m_ds = !m_ds; exp_done = 1'b1; m_mode = MODE_RUN; m_cpu_age = 0;
                end
            end
            default: begin
                if (!hr) begin
                    m_mode = MODE_RUN; exp_ack = 1'b0; m_cpu_age = 0;
                end else if (STEP_EN && st) begin
                    exp_ce_cpu = 1'b1;
                end
            end
        endcase
        if (!sw) m_armed = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        cyc++;
        check("ce_cpu", ctrl.ce_cpu, exp_ce_cpu);
        check("ce_ppu", ctrl.ce_ppu, exp_ce_ppu);
        check("switch_done", ctrl.switch_done, exp_done);
        check("double_speed", ctrl.double_speed, m_ds);
        check("halt_ack", ctrl.halt_ack, exp_ack);
        if (ctrl.ce_cpu === 1'b1) begin n_cpu++; last_cpu_cyc = cyc; end
        if (ctrl.ce_ppu === 1'b1) begin
            if (chk_ppu_gap && last_ppu_cyc > 0) check("ppu_period", cyc - last_ppu_cyc, DIV_N);
            n_ppu++; last_ppu_cyc = cyc;
        end
        if (ctrl.switch_done === 1'b1) begin n_done++; done_cyc = cyc; end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        check("rst_ce_cpu", ctrl.ce_cpu, 0);
        check("rst_ce_ppu", ctrl.ce_ppu, 0);
        check("rst_double_speed", ctrl.double_speed, 0);
        check("rst_switch_done", ctrl.switch_done, 0);
        check("rst_halt_ack", ctrl.halt_ack, 0);
        repeat (2) @(posedge clk_in);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int n, c0, p0, d0, t0, mis, lows, hold;
        reset_n = 1'b0;
        ctrl.switch_req = 1'b0;
        ctrl.halt_req   = 1'b0;
        ctrl.step       = 1'b0;
        model_reset();

        // 1: free run after reset
        do_reset();
        c0 = n_cpu; p0 = n_ppu; mis = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == DIV_N - 1) check("first_ce_cpu_edge", ctrl.ce_cpu, 1);
            if (ctrl.ce_cpu !== ctrl.ce_ppu) mis++;
        end
        check("t1_cpu_count", n_cpu - c0, 25);
        check("t1_ppu_count", n_ppu - p0, 25);
        check("t1_in_phase", mis, 0);

        // 2: single speed switch
        chk_ppu_gap = 1'b1;
        repeat ($urandom_range(0, 7)) tick();
        ctrl.switch_req = 1'b1;
        n = 0;
        d0 = n_done;
        while (n_done == d0 && n < SW_CYC + 50) begin tick(); n++; end
        check("t2_switch_done_seen", n_done - d0, 1);
        check("t2_silent_span", done_cyc - last_cpu_cyc, SW_CYC + DIV_N);
        check("t2_double_speed", ctrl.double_speed, 1);
        c0 = n_cpu; p0 = n_ppu; d0 = n_done;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == DIV_D - 1) check("t2_first_fast_ce", ctrl.ce_cpu, 1);
        end
        check("t2_fast_cpu_count", n_cpu - c0, 20);
        check("t2_ppu_count", n_ppu - p0, 10);

        // 3: held switch_req does not re-trigger; a one-cycle drop re-arms
        check("t3_no_second_switch", n_done - d0, 0);
        ctrl.switch_req = 1'b0;
        tick();
        ctrl.switch_req = 1'b1;
        n = 0;
        d0 = n_done;
        while (n_done == d0 && n < SW_CYC + 50) begin tick(); n++; end
        check("t3_switch_back_seen", n_done - d0, 1);
        check("t3_normal_speed", ctrl.double_speed, 0);
        c0 = n_cpu;
        repeat (40) tick();
        check("t3_normal_cpu_count", n_cpu - c0, 10);
        ctrl.switch_req = 1'b0;
        chk_ppu_gap = 1'b0;

        // 4: halt raised mid-period
        repeat ($urandom_range(1, 3)) tick();
        ctrl.halt_req = 1'b1;
        n = 0;
        while (ctrl.halt_ack !== 1'b1 && n < 10) begin tick(); n++; end
        check("t4_halt_ack_seen", ctrl.halt_ack, 1);
        check("t4_halt_at_boundary", cyc - last_cpu_cyc, DIV_N);
        c0 = n_cpu; p0 = n_ppu;
        hold = $urandom_range(5, 20);
        repeat (hold) tick();
        check("t4_cpu_while_halted", n_cpu - c0, 0);
        check("t4_ppu_while_halted", n_ppu - p0, 0);
        ctrl.halt_req = 1'b0;
        tick();
        check("t4_halt_ack_drop", ctrl.halt_ack, 0);
        t0 = cyc;
        n = 0;
        c0 = n_cpu;
        while (n_cpu == c0 && n < 10) begin tick(); n++; end
        check("t4_resume_latency", cyc - t0, DIV_N);

        // 5: switch and halt at the same boundary, then reset mid-switch
        repeat ($urandom_range(0, 3)) tick();
        ctrl.switch_req = 1'b1;
        ctrl.halt_req   = 1'b1;
        n = 0;
        d0 = n_done;
        while (n_done == d0 && n < SW_CYC + 50) begin tick(); n++; end
        check("t5_switch_first", n_done - d0, 1);
        check("t5_ack_low_at_done", ctrl.halt_ack, 0);
        n = 0;
        while (ctrl.halt_ack !== 1'b1 && n < 10) begin tick(); n++; end
        check("t5_halt_after_switch", cyc - done_cyc, DIV_D);
        ctrl.switch_req = 1'b0;
        ctrl.halt_req   = 1'b0;
        repeat (6) tick();
        ctrl.switch_req = 1'b1;
        n = 0;
        while (!(m_mode == MODE_SWITCH && m_sw_elapsed == SW_CYC - 1 - 100) && n < SW_CYC + 50) begin
            tick(); n++;
        end
        check("t5_reached_wait_100", m_sw_elapsed, SW_CYC - 1 - 100);
        ctrl.switch_req = 1'b0;
        d0 = n_done;
        do_reset();
        repeat (150) tick();
        check("t5_no_done_after_reset", n_done - d0, 0);
        check("t5_speed_after_reset", ctrl.double_speed, 0);

        // 6: step pulses while halted
        ctrl.halt_req = 1'b1;
        n = 0;
        while (ctrl.halt_ack !== 1'b1 && n < 10) begin tick(); n++; end
        check("t6_halt_ack_seen", ctrl.halt_ack, 1);
        c0 = n_cpu; p0 = n_ppu; lows = 0;
        ctrl.step = 1'b1; tick(); if (ctrl.halt_ack !== 1'b1) lows++;
        ctrl.step = 1'b0;
        repeat ($urandom_range(1, 3)) begin tick(); if (ctrl.halt_ack !== 1'b1) lows++; end
        ctrl.step = 1'b1; tick(); if (ctrl.halt_ack !== 1'b1) lows++;
        tick(); if (ctrl.halt_ack !== 1'b1) lows++;
        ctrl.step = 1'b0;
        repeat (3) begin tick(); if (ctrl.halt_ack !== 1'b1) lows++; end
        check("t6_step_cpu_count", n_cpu - c0, STEP_EN ? 3 : 0);
        check("t6_ppu_frozen", n_ppu - p0, 0);
        check("t6_halt_ack_held", lows, 0);
        ctrl.halt_req = 1'b0;

        // random soak of halt/step activity at normal speed
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ctrl.halt_req = ~ctrl.halt_req;
            ctrl.step = ($urandom_range(0, 2) == 0);
            tick();
        end
        ctrl.halt_req = 1'b0;
        ctrl.step     = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
